// File: rtl/layer_controller.sv
// ---------------------------------------------------------------------------
// layer_controller
//
// Initiator side of the neuron start/done handshake for one fully-connected
// layer. An input vector arrives as a word stream and is buffered. The full
// vector is then broadcast to every neuron and a one-cycle start pulse is
// issued. Each neuron's result is captured when its done pulse arrives, and
// the layer outputs are then streamed downstream in neuron-index order.
//
// Optional feature macro: LAYER_CTRL_RELU_EN
//   defined   - negative neuron results are stored as 0 (hidden layers)
//   undefined - results pass through bit-exact (output layer)
//
// Parameters:
//   INPUT_SIZE  - words per input vector (matches the neurons' INPUT_SIZE)
//   NUM_NEURONS - neurons in the layer (>= 1)
//   IDX_W       - index counter width, 2^IDX_W > max(INPUT_SIZE, NUM_NEURONS)
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - input word handshake
//   in_data, in_last     - signed input word, end-of-vector marker
//   vec_out              - buffered vector, word i at [16*i +: 16]
//   start                - one-cycle start pulse to all neurons
//   done_in, result_in   - per-neuron done pulses and signed results
//   out_valid/out_ready  - output word handshake
//   out_data, out_index  - signed neuron result and its neuron index
//   out_last             - marks the result of neuron NUM_NEURONS-1
//   busy                 - high while firing, waiting or draining
//   err_len              - one-cycle flag for a short or long input vector
// ---------------------------------------------------------------------------
module layer_controller #(
    parameter int INPUT_SIZE  = 784,
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [15:0]          in_data,
    input  logic                        in_last,
    output logic [16*INPUT_SIZE-1:0]    vec_out,
    output logic                        start,
    input  logic [NUM_NEURONS-1:0]      done_in,
    input  logic [16*NUM_NEURONS-1:0]   result_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [15:0]          out_data,
    output logic [IDX_W-1:0]            out_index,
    output logic                        out_last,
    output logic                        busy,
    output logic                        err_len
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         wr_idx;
    logic [IDX_W-1:0]         out_idx;
    logic [16*INPUT_SIZE-1:0] vec_buf;
    logic signed [15:0]       res_buf [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]   done_seen;

    logic                     accept;
    logic                     at_end;
    logic [NUM_NEURONS-1:0]   seen_next;
    logic [NUM_NEURONS-1:0]   first_done;
    logic [IDX_W-1:0]         next_idx;
    logic signed [15:0]       next_word;
    logic signed [15:0]       first_word;
    logic signed [15:0]       cap_val [NUM_NEURONS];

    function automatic logic signed [15:0] relu(input logic signed [15:0] v);
`ifdef LAYER_CTRL_RELU_EN
        return v[15] ? 16'sd0 : v;
`else
        return v;
`endif
    endfunction

    assign vec_out    = vec_buf;
    assign accept     = in_valid & in_ready;
    assign at_end     = (wr_idx == IDX_W'(INPUT_SIZE - 1));
    assign seen_next  = done_seen | done_in;
    // Only the first done pulse of each neuron is captured; repeats are ignored.
    assign first_done = done_in & ~done_seen;
    assign next_idx   = out_idx + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            cap_val[i] = relu(result_in[16*i +: 16]);
        end
    end

    // Word 0 may be captured on the same edge that enters DRAIN, so bypass it.
    assign first_word = first_done[0] ? cap_val[0] : res_buf[0];

    always_comb begin
        next_word = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (next_idx == IDX_W'(i)) begin
                next_word = res_buf[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            wr_idx    <= '0;
            out_idx   <= '0;
            vec_buf   <= '0;
            done_seen <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                res_buf[i] <= '0;
            end
            in_ready  <= 1'b1;
            start     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < INPUT_SIZE; i++) begin
                            if (wr_idx == IDX_W'(i)) begin
                                vec_buf[16*i +: 16] <= in_data;
                            end
                        end
                        wr_idx <= wr_idx + IDX_W'(1);
                        if (in_last || at_end) begin
                            state    <= FIRE;
                            start    <= 1'b1;
                            // in_last away from the final slot is short; the
                            // final slot without in_last is long.
                            err_len  <= in_last ^ at_end;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end

                FIRE: begin
                    start     <= 1'b0;
                    err_len   <= 1'b0;
                    done_seen <= '0;
                    state     <= WAIT;
                end

                WAIT: begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        if (first_done[i]) begin
                            res_buf[i] <= cap_val[i];
                        end
                    end
                    done_seen <= seen_next;
                    if (&seen_next) begin
                        state     <= DRAIN;
                        out_idx   <= '0;
                        out_valid <= 1'b1;
                        out_data  <= first_word;
                        out_index <= '0;
                        out_last  <= (NUM_NEURONS == 1);
                    end
                end

                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= LOAD;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_index <= '0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                            vec_buf   <= '0;
                            wr_idx    <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            out_idx   <= next_idx;
                            out_index <= next_idx;
                            out_data  <= next_word;
                            out_last  <= (next_idx == IDX_W'(NUM_NEURONS - 1));
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_controller.sv
// ---------------------------------------------------------------------------
// tb_layer_controller
//
// Directed testbench for layer_controller with INPUT_SIZE=4, NUM_NEURONS=3.
// The bench plays the role of the upstream stream source, the three neurons
// and the downstream sink. Expected values are hand-computed constants;
// ReLU expectations follow LAYER_CTRL_RELU_EN.
// ---------------------------------------------------------------------------
module tb_layer_controller;

    localparam int IS = 4;
    localparam int NN = 3;
    localparam int IW = 4;

    typedef int arr8_t [8];
    typedef int arr3_t [3];

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [15:0]   in_data = '0;
    logic                 in_last = 1'b0;
    logic [16*IS-1:0]     vec_out;
    logic                 start;
    logic [NN-1:0]        done_in = '0;
    logic [16*NN-1:0]     result_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [15:0]   out_data;
    logic [IW-1:0]        out_index;
    logic                 out_last;
    logic                 busy;
    logic                 err_len;

    int total = 0;
    int bad = 0;
    int start_cnt = 0;
    int err_cnt = 0;

    layer_controller #(
        .INPUT_SIZE (IS),
        .NUM_NEURONS(NN),
        .IDX_W      (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .vec_out  (vec_out),
        .start    (start),
        .done_in  (done_in),
        .result_in(result_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy),
        .err_len  (err_len)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (start) start_cnt++;
        if (err_len) err_cnt++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int vecWord(input int i);
        logic signed [15:0] w;
        w = vec_out[16*i +: 16];
        return w;
    endfunction

    function automatic int expRelu(input int x);
`ifdef LAYER_CTRL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    // Stream n words; in_last on the final word when with_last is set
    task automatic applyStimulus(input int n, input arr8_t words, input bit with_last);
        for (int k = 0; k < n; k++) begin
            int guard;
            in_valid = 1'b1;
            in_data  = 16'(words[k]);
            in_last  = with_last && (k == n - 1);
            guard = 0;
            while (!in_ready && guard < 200) begin
                tick();
                guard++;
            end
            if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for start, check fire-cycle outputs, then play the neurons.
    // d[j] is the cycle offset after start at which neuron j pulses done.
    // rep_off > 0 adds a repeat done on neuron 0 with rep_res.
    task automatic runNeurons(input int exp_err, input arr8_t exp_vec, input arr3_t d,
                              input arr3_t r, input int rep_off, input int rep_res);
        int guard;
        int maxd;
        guard = 0;
        while (!start && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("start_seen", int'(start), 1);
        checkOutput("err_len_at_start", int'(err_len), exp_err);
        for (int i = 0; i < IS; i++) begin
            checkOutput($sformatf("vec_out[%0d]", i), vecWord(i), exp_vec[i]);
        end
        checkOutput("busy_fire", int'(busy), 1);
        checkOutput("in_ready_fire", int'(in_ready), 0);
        maxd = 1;
        for (int j = 0; j < NN; j++) if (d[j] > maxd) maxd = d[j];
        for (int off = 1; off <= maxd; off++) begin
            tick();
            if (off == maxd) checkOutput("out_valid_before_last_done", int'(out_valid), 0);
            done_in = '0;
            for (int j = 0; j < NN; j++) begin
                if (d[j] == off) begin
                    done_in[j] = 1'b1;
                    result_in[16*j +: 16] = 16'(r[j]);
                end
            end
            if (rep_off == off) begin
                done_in[0] = 1'b1;
                result_in[15:0] = 16'(rep_res);
            end
        end
        tick();
        done_in = '0;
        checkOutput("out_valid_rise", int'(out_valid), 1);
    endtask

    // Drain three words; stall_idx >= 0 holds out_ready low 3 cycles there
    task automatic drainCheck(input arr3_t exp_res, input int stall_idx);
        for (int idx = 0; idx < NN; idx++) begin
            checkOutput($sformatf("out_valid[%0d]", idx), int'(out_valid), 1);
            checkOutput($sformatf("out_index[%0d]", idx), int'(out_index), idx);
            checkOutput($sformatf("out_data[%0d]", idx), int'(out_data), exp_res[idx]);
            checkOutput($sformatf("out_last[%0d]", idx), int'(out_last), (idx == NN - 1) ? 1 : 0);
            checkOutput($sformatf("in_ready_drain[%0d]", idx), int'(in_ready), 0);
            if (idx == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    checkOutput("stall_valid", int'(out_valid), 1);
                    checkOutput("stall_index", int'(out_index), idx);
                    checkOutput("stall_data", int'(out_data), exp_res[idx]);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        checkOutput("in_ready_after_drain", int'(in_ready), 1);
        checkOutput("out_valid_after_drain", int'(out_valid), 0);
        checkOutput("busy_after_drain", int'(busy), 0);
    endtask

    initial begin
        int s0;
        int e0;
        bit any_valid;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_in_ready", int'(in_ready), 1);
        checkOutput("rst_start", int'(start), 0);
        checkOutput("rst_out_valid", int'(out_valid), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_err_len", int'(err_len), 0);
        checkOutput("rst_out_data", int'(out_data), 0);
        checkOutput("rst_out_index", int'(out_index), 0);
        checkOutput("rst_out_last", int'(out_last), 0);
        for (int i = 0; i < IS; i++) checkOutput("rst_vec", vecWord(i), 0);
        rst_n = 1'b1;
        tick();

        // Nominal
        $display("[TB] nominal");
        s0 = start_cnt;
        e0 = err_cnt;
        applyStimulus(4, '{1, 2, 3, 4, 0, 0, 0, 0}, 1'b1);
        runNeurons(0, '{1, 2, 3, 4, 0, 0, 0, 0}, '{1, 1, 1}, '{10, -5, 7}, 0, 0);
        drainCheck('{10, expRelu(-5), 7}, -1);
        checkOutput("nominal_start_pulses", start_cnt - s0, 1);
        checkOutput("nominal_err_pulses", err_cnt - e0, 0);

        // Staggered done with a repeat from neuron 0
        $display("[TB] staggered done");
        applyStimulus(4, '{11, 12, 13, 14, 0, 0, 0, 0}, 1'b1);
        runNeurons(0, '{11, 12, 13, 14, 0, 0, 0, 0}, '{1, 5, 3}, '{100, 200, -300}, 4, 999);
        drainCheck('{100, 200, expRelu(-300)}, -1);

        // Short vector
        $display("[TB] short vector");
        e0 = err_cnt;
        applyStimulus(2, '{9, 8, 0, 0, 0, 0, 0, 0}, 1'b1);
        runNeurons(1, '{9, 8, 0, 0, 0, 0, 0, 0}, '{1, 1, 1}, '{1, 2, 3}, 0, 0);
        drainCheck('{1, 2, 3}, -1);
        checkOutput("short_err_pulses", err_cnt - e0, 1);

        // Long vector: the fifth word waits and becomes word 0 of the next
        $display("[TB] long vector");
        s0 = start_cnt;
        fork
            applyStimulus(5, '{1, 2, 3, 4, 5, 0, 0, 0}, 1'b0);
            begin
                runNeurons(1, '{1, 2, 3, 4, 0, 0, 0, 0}, '{2, 1, 1}, '{4, 5, 6}, 0, 0);
                drainCheck('{4, 5, 6}, -1);
            end
        join
        checkOutput("long_start_pulses", start_cnt - s0, 1);
        checkOutput("long_carry_word0", vecWord(0), 5);
        checkOutput("long_carry_in_ready", int'(in_ready), 1);
        checkOutput("long_carry_busy", int'(busy), 0);
        applyStimulus(3, '{6, 7, 8, 0, 0, 0, 0, 0}, 1'b1);
        runNeurons(0, '{5, 6, 7, 8, 0, 0, 0, 0}, '{1, 2, 3}, '{-1, 0, 32767}, 0, 0);
        drainCheck('{expRelu(-1), 0, 32767}, -1);

        // Back-pressure during index 1
        $display("[TB] back-pressure");
        applyStimulus(4, '{-4, -3, -2, -1, 0, 0, 0, 0}, 1'b1);
        runNeurons(0, '{-4, -3, -2, -1, 0, 0, 0, 0}, '{1, 1, 2}, '{20, 21, 22}, 0, 0);
        drainCheck('{20, 21, 22}, 1);

        // Reset during WAIT
        $display("[TB] reset mid-wait");
        applyStimulus(4, '{21, 22, 23, 24, 0, 0, 0, 0}, 1'b1);
        checkOutput("rw_start", int'(start), 1);
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rw_busy", int'(busy), 0);
        checkOutput("rw_in_ready", int'(in_ready), 1);
        checkOutput("rw_out_valid", int'(out_valid), 0);
        checkOutput("rw_start_low", int'(start), 0);
        for (int i = 0; i < IS; i++) checkOutput("rw_vec", vecWord(i), 0);
        tick();
        rst_n = 1'b1;
        s0 = start_cnt;
        done_in = '1;
        tick();
        done_in = '0;
        any_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) any_valid = 1'b1;
            tick();
        end
        checkOutput("rw_no_out_valid", int'(any_valid), 0);
        checkOutput("rw_no_start", start_cnt - s0, 0);
        checkOutput("rw_in_ready_after", int'(in_ready), 1);

        // Recovery after reset
        applyStimulus(4, '{31, 32, 33, 34, 0, 0, 0, 0}, 1'b1);
        runNeurons(0, '{31, 32, 33, 34, 0, 0, 0, 0}, '{1, 1, 1}, '{-7, 8, -9}, 0, 0);
        drainCheck('{expRelu(-7), 8, expRelu(-9)}, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
